// File: rtl/fetch_unit.sv
// Instruction fetch/branch unit: holds PC and IR, decodes instruction fields,
// resolves conditional branches and BX targets, and counts retired fetches.
module fetch_unit #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            loadir,
  input  logic            incp,
  input  logic            execb,
  input  logic            tsel,
  input  logic            msel,
  input  logic [1:0]      nsel,
  input  logic [15:0]     mdata,
  input  logic [PC_W-1:0] ra,
  input  logic [PC_W-1:0] c_addr,
  input  logic [2:0]      status,
  output logic [15:0]     ir,
  output logic [2:0]      opcode,
  output logic [1:0]      op,
  output logic [2:0]      regnum,
  output logic [15:0]     sximm8,
  output logic [15:0]     sximm5,
  output logic [1:0]      shift,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next_seq,
  output logic [PC_W-1:0] mem_addr,
  output logic            taken,
  output logic [15:0]     retired
);

  logic            flag_z;
  logic            flag_n;
  logic            flag_v;
  logic            cond;
  logic            branch_applied;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_d;

  assign {flag_z, flag_n, flag_v} = status;

  // Instruction field decode
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign shift  = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  always_comb begin
    regnum = 3'b000;
    case (nsel)
      2'b00:   regnum = ir[10:8];
      2'b01:   regnum = ir[7:5];
      2'b10:   regnum = ir[2:0];
      default: regnum = 3'b000;
    endcase
  end

  assign pc_next_seq = pc + PC_W'(1);
  assign mem_addr    = msel ? c_addr : pc;

  // Branch condition; opcodes other than B<cc> and BL never branch via tsel
  always_comb begin
    cond = 1'b0;
    if (opcode == 3'b001) begin
      case (ir[10:8])
        3'b000:  cond = 1'b1;
        3'b001:  cond = flag_z;
        3'b010:  cond = ~flag_z;
        3'b011:  cond = flag_n ^ flag_v;
        3'b100:  cond = (flag_n ^ flag_v) | flag_z;
        default: cond = 1'b0;
      endcase
    end else if (opcode == 3'b010) begin
      cond = 1'b1;
    end
  end

  assign br_target      = pc + PC_W'({{PC_W{ir[7]}}, ir[7:0]});
  assign branch_applied = execb & (~tsel | cond);

  // Next PC: a branch/BX strobe overrides the sequential increment
  always_comb begin
    pc_d = pc;
    if (execb) begin
      if (branch_applied) pc_d = tsel ? br_target : ra;
    end else if (incp) begin
      pc_d = pc_next_seq;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      taken <= 1'b0;
    end else begin
      pc <= pc_d;
      if (execb) taken <= branch_applied;
    end
  end

  // IR load and saturating retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir      <= 16'h0000;
      retired <= 16'h0000;
    end else if (loadir) begin
      ir <= mdata;
      if (retired != 16'hFFFF) retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: decode vector table, directed branch and
// reset sequences, and randomized cycles against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        loadir = 1'b0, incp = 1'b0, execb = 1'b0, tsel = 1'b0, msel = 1'b0;
  logic [1:0]  nsel = 2'b00;
  logic [15:0] mdata = 16'h0000;
  logic [7:0]  ra = 8'h00, c_addr = 8'h00;
  logic [2:0]  status = 3'b000;
  logic [15:0] ir, sximm8, sximm5, retired;
  logic [2:0]  opcode, regnum;
  logic [1:0]  op, shift;
  logic [7:0]  pc, pc_next_seq, mem_addr;
  logic        taken;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.PC_W(8)) dut (
    .clk(clk), .reset(reset), .loadir(loadir), .incp(incp), .execb(execb),
    .tsel(tsel), .msel(msel), .nsel(nsel), .mdata(mdata), .ra(ra),
    .c_addr(c_addr), .status(status), .ir(ir), .opcode(opcode), .op(op),
    .regnum(regnum), .sximm8(sximm8), .sximm5(sximm5), .shift(shift),
    .pc(pc), .pc_next_seq(pc_next_seq), .mem_addr(mem_addr), .taken(taken),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mdata;
    logic [1:0]  nsel;
    logic        msel;
    logic [7:0]  c_addr;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  regnum;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [7:0]  mem_addr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Model helpers derived from the instruction set rules
  function automatic int sx8(input logic [15:0] i);
    int v;
    v = int'(i[7:0]);
    if (v >= 128) v -= 256;
    return v;
  endfunction

  function automatic bit branch_ok(input logic [15:0] i, input logic [2:0] st);
    bit z, lt;
    bit [7:0] table_cc;
    z  = st[2];
    lt = st[1] != st[0];
    table_cc = {3'b000, lt | z, lt, !z, z, 1'b1};
    if (i[15:13] == 3'b001) return table_cc[i[10:8]];
    return i[15:13] == 3'b010;
  endfunction

  function automatic int reg_model(input logic [15:0] i, input logic [1:0] s);
    if (s == 2'd0) return int'(i >> 8) & 7;
    if (s == 2'd1) return int'(i >> 5) & 7;
    if (s == 2'd2) return int'(i) & 7;
    return 0;
  endfunction

  initial begin
    vecs[0] = '{16'hA3E9, 2'd0, 1'b0, 8'h00, 3'b101, 2'b00, 3'b011, 2'b01, 16'hFFE9, 16'h0009, 8'h00};
    vecs[1] = '{16'hA3E9, 2'd1, 1'b0, 8'h00, 3'b101, 2'b00, 3'b111, 2'b01, 16'hFFE9, 16'h0009, 8'h00};
    vecs[2] = '{16'hA3E9, 2'd2, 1'b0, 8'h00, 3'b101, 2'b00, 3'b001, 2'b01, 16'hFFE9, 16'h0009, 8'h00};
    vecs[3] = '{16'hA3E9, 2'd3, 1'b1, 8'h22, 3'b101, 2'b00, 3'b000, 2'b01, 16'hFFE9, 16'h0009, 8'h22};
    vecs[4] = '{16'hD105, 2'd1, 1'b0, 8'h5A, 3'b110, 2'b10, 3'b000, 2'b00, 16'h0005, 16'h0005, 8'h00};
    vecs[5] = '{16'h21FE, 2'd2, 1'b0, 8'h11, 3'b001, 2'b00, 3'b110, 2'b11, 16'hFFFE, 16'hFFFE, 8'h00};
    vecs[6] = '{16'h7F10, 2'd0, 1'b1, 8'h9C, 3'b011, 2'b11, 3'b111, 2'b10, 16'h0010, 16'hFFF0, 8'h9C};

    // Reset state
    #2;
    check("reset_state", {pc, ir, taken, retired}, 41'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // First fetch: loadir+incp together
    mdata = 16'hD105; loadir = 1'b1; incp = 1'b1;
    tick();
    loadir = 1'b0; incp = 1'b0;
    check("first_fetch_ir", ir, 16'hD105);
    check("first_fetch_dec", {opcode, op, pc, retired, mem_addr}, {3'b110, 2'b10, 8'h01, 16'h0001, 8'h01});

    // Decode table, pc held at 0
    do_reset();
    for (int k = 0; k < 7; k++) begin
      mdata = vecs[k].mdata; loadir = 1'b1;
      tick();
      loadir = 1'b0;
      nsel = vecs[k].nsel; msel = vecs[k].msel; c_addr = vecs[k].c_addr;
      #1;
      check($sformatf("decode_%0d", k),
            {opcode, op, regnum, shift, sximm8, sximm5},
            {vecs[k].opcode, vecs[k].op, vecs[k].regnum, vecs[k].shift, vecs[k].sximm8, vecs[k].sximm5});
      check($sformatf("ir_addr_%0d", k), {ir, mem_addr}, {vecs[k].mdata, vecs[k].mem_addr});
    end
    msel = 1'b0;

    // BEQ -2 from pc=5, taken then not taken
    do_reset();
    incp = 1'b1;
    repeat (5) tick();
    incp = 1'b0;
    check("pc_after_5_incp", pc, 8'h05);
    mdata = 16'h21FE; loadir = 1'b1;
    tick();
    loadir = 1'b0;
    status = 3'b100; execb = 1'b1; tsel = 1'b1;
    tick();
    execb = 1'b0; tsel = 1'b0;
    check("beq_taken", {pc, taken}, {8'h03, 1'b1});
    incp = 1'b1;
    repeat (2) tick();
    incp = 1'b0;
    status = 3'b000; execb = 1'b1; tsel = 1'b1;
    tick();
    execb = 1'b0; tsel = 1'b0;
    check("beq_not_taken", {pc, taken}, {8'h05, 1'b0});

    // PC wrap on increment and on branch
    ra = 8'hFF; execb = 1'b1;
    tick();
    execb = 1'b0;
    check("bx_to_ff", {pc, pc_next_seq}, {8'hFF, 8'h00});
    incp = 1'b1;
    tick();
    incp = 1'b0;
    check("incp_wrap", pc, 8'h00);
    ra = 8'hFE; execb = 1'b1;
    tick();
    execb = 1'b0;
    mdata = 16'h2003; loadir = 1'b1;
    tick();
    loadir = 1'b0;
    execb = 1'b1; tsel = 1'b1;
    tick();
    execb = 1'b0; tsel = 1'b0;
    check("branch_wrap", {pc, taken}, {8'h01, 1'b1});

    // BX with incp: execb wins
    mdata = 16'h4000; loadir = 1'b1;
    tick();
    loadir = 1'b0;
    ra = 8'h40; execb = 1'b1; tsel = 1'b0; incp = 1'b1;
    tick();
    execb = 1'b0; incp = 1'b0;
    check("bx_priority", {pc, taken}, {8'h40, 1'b1});

    // Reset asserted mid-cycle during a BX
    ra = 8'h77; execb = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset", {pc, ir, taken, retired}, 41'h0);
    loadir = 1'b1; incp = 1'b1; mdata = 16'hBEEF;
    tick();
    check("strobes_in_reset", {pc, ir, taken, retired}, 41'h0);
    loadir = 1'b0; incp = 1'b0; execb = 1'b0;
    #2 reset = 1'b1;
    tick();
    check("idle_after_release", {pc, retired}, 24'h0);

    // Randomized cycles against the model
    do_reset();
    begin
      int m_pc, m_ret, n_pc, n_ret;
      logic [15:0] m_ir, n_ir;
      logic m_taken, n_taken;
      bit go;
      m_pc = 0; m_ret = 0; m_ir = 16'h0; m_taken = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        loadir = 1'($urandom_range(0, 1));
        incp   = 1'($urandom_range(0, 1));
        execb  = ($urandom_range(0, 3) == 0);
        tsel   = 1'($urandom_range(0, 1));
        msel   = 1'($urandom_range(0, 1));
        nsel   = 2'($urandom_range(0, 3));
        mdata  = 16'($urandom);
        ra     = 8'($urandom);
        c_addr = 8'($urandom);
        status = 3'($urandom_range(0, 7));
        #1;
        check("rand_comb",
              {mem_addr, regnum, pc_next_seq},
              {8'(msel ? int'(c_addr) : m_pc), 3'(reg_model(m_ir, nsel)), 8'((m_pc + 1) % 256)});
        n_pc = m_pc; n_taken = m_taken;
        if (execb) begin
          go = tsel ? branch_ok(m_ir, status) : 1'b1;
          if (go) n_pc = tsel ? (m_pc + sx8(m_ir) + 256) % 256 : int'(ra);
          n_taken = go;
        end else if (incp) begin
          n_pc = (m_pc + 1) % 256;
        end
        n_ir  = loadir ? mdata : m_ir;
        n_ret = (loadir && m_ret < 65535) ? m_ret + 1 : m_ret;
        tick();
        m_pc = n_pc; m_ir = n_ir; m_ret = n_ret; m_taken = n_taken;
        check("rand_state", {pc, ir, taken, retired},
              {8'(m_pc), m_ir, m_taken, 16'(m_ret)});
      end
    end
    loadir = 1'b0; incp = 1'b0; execb = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
